alu_mult_seq: RTL
=================

# alu_mult_seq

Multi-cycle unsigned multiply sequencer that time-shares the execute-stage ALU to implement MULTU without a dedicated multiplier array. It runs a shift-and-add algorithm, issuing ALU_ADD and ALU_SLTU operations over the ALU's operand/opcode ports while it holds the ALU grant, and keeps the partial product in local HI/LO registers. It sits beside the ALU in the execute stage. The datapath mux hands ALU ports to this block whenever `alu_req` is high, and the hazard unit stalls the pipeline while `busy` is high.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- OPW, 4, ALU opcode width (matches ALU interface opcode field)
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous reset, active-high: nRST=1 immediately clears all state
- start  in  1  one-cycle request; sampled only in IDLE
- mcand  in  WIDTH  multiplicand, captured when start accepted
- mplier  in  WIDTH  multiplier, captured when start accepted
- busy  out  1  high from cycle after accept until DONE inclusive
- done  out  1  one-cycle pulse, product valid
- hi  out  WIDTH  upper product word (registered)
- lo  out  WIDTH  lower product word (registered)
- alu_req  out  1  block owns ALU ports this cycle
- alu_op  out  OPW  opcode to ALU (ALU_ADD / ALU_SLTU encodings)
- alu_a  out  WIDTH  ALU port A
- alu_b  out  WIDTH  ALU port B
- alu_out  in  WIDTH  ALU combinational result, same cycle

## Operation
- States: IDLE, ADD, CSHIFT, SHIFT, DONE. Registers: hi, lo, mc (multiplicand), cnt (clog2(WIDTH) bits).
- IDLE, start=1: hi<=0, lo<=mplier, mc<=mcand, cnt<=0. Next state is ADD if mplier[0]=1, else SHIFT.
- ADD: alu_req=1, alu_op=ALU_ADD, alu_a=hi, alu_b=mc. Update hi<=alu_out. Next state CSHIFT.
- CSHIFT: alu_req=1, alu_op=ALU_SLTU, alu_a=hi (the sum), alu_b=mc. The carry is alu_out[0] (sum < mc means unsigned overflow). Update {hi,lo}<={carry,hi,lo}>>1 and cnt++.
- SHIFT: alu_req=0. Update {hi,lo}<={1'b0,hi,lo}>>1 and cnt++.
- After CSHIFT/SHIFT: if cnt was WIDTH-1, go to DONE. Otherwise go to ADD if the new lo[0] (old lo[1]) is 1, else SHIFT.
- DONE: done=1, busy=1. Next state IDLE. hi/lo hold the final product until the next accepted start.
- When alu_req=0: alu_op=ALU_ADD, alu_a=0, alu_b=0 (deterministic, ignored by the mux).
- start outside IDLE is ignored: no queueing, no effect on the running operation.
- Product is exact unsigned 2*WIDTH. No signed mode; the signed MULT fix-up is out of scope.
- Reset values (also when reset is asserted mid-operation): state=IDLE, hi=lo=mc=0, cnt=0, busy=0, done=0, alu_req=0, alu_op=ALU_ADD, alu_a=alu_b=0. In-flight operation is discarded.

## Timing
- Start accepted at edge E0. busy rises after E0.
- Each multiplier bit costs 1 cycle if 0 (SHIFT) or 2 cycles if 1 (ADD+CSHIFT).
- Total busy cycles = WIDTH + popcount(mplier) + 1 (DONE). done is high in the last busy cycle.
- Minimum latency is 33 cycles (mplier=0). Maximum is 65 cycles (mplier all ones).
- A new start is accepted in the IDLE cycle immediately after DONE, so back-to-back operations have one idle cycle between them.
- busy, done, alu_req and alu_op/a/b are decoded from registered state only, with no combinational path from start. alu_out is sampled only at edges in ADD and CSHIFT.
- Asynchronous reset takes effect without a clock edge. Release is synchronous to the next edge as normal.

## Test plan
- Bench ALU model implements ADD and SLTU combinationally on alu_a/alu_b/alu_op.
- 3 × 5, start at E0 -> done high in cycle 35 after E0; hi=0x00000000, lo=0x0000000F; alu_req high exactly 4 cycles.
- 0xFFFFFFFF × 0xFFFFFFFF -> 65 busy cycles; hi=0xFFFFFFFE, lo=0x00000001; every CSHIFT after the first add sees carry=1 at the correct bits.
- 0x12345678 × 0 -> 33 busy cycles, alu_req never high; hi=lo=0.
- start pulsed every cycle during an operation of 7 × 9 -> result is still 63, with exactly one done pulse. The next start is accepted only in the IDLE cycle after DONE.
- nRST asserted during cycle 10 of 0x80000000 × 0x80000000 -> all outputs 0 immediately, state IDLE. A subsequent 2 × 2 gives lo=4 with normal latency (34 cycles).
- 0x80000000 × 2 -> hi=0x00000001, lo=0x00000000, checking the carry-less high-word shift path.

Source files
------------

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: multi-cycle unsigned multiplier (MULTU) that borrows the
// execute-stage ALU for its additions and carry detection. Shift-and-add,
// LSB first; the partial product lives in hi/lo, and the multiplier is
// consumed out of lo as the product shifts in from the top.
//
// Handshake: start is a single-cycle request that is only looked at while
// the FSM is in IDLE; anything on start at other times is dropped. busy
// is high from the cycle after acceptance up to and including the DONE
// cycle, and done pulses for exactly that last cycle with hi/lo valid.
// hi/lo then hold the product until the next accepted start.
module alu_mult_seq #(
    parameter int WIDTH         = 32,
    parameter int OPW           = 4,
    parameter int ALU_ADD_ENC   = 0,
    parameter int ALU_SLTU_ENC  = 3
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_req,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic [2:0]       fsm_state
);

    localparam int CNTW = $clog2(WIDTH);
    localparam logic [OPW-1:0]  OP_ADD   = OPW'(ALU_ADD_ENC);
    localparam logic [OPW-1:0]  OP_SLTU  = OPW'(ALU_SLTU_ENC);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADD    = 3'd1,
        S_CSHIFT = 3'd2,
        S_SHIFT  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  mc;
    logic [CNTW-1:0]   cnt;
    logic              last_bit;

    // The bit being retired by CSHIFT/SHIFT is the final multiplier bit.
    assign last_bit  = (cnt == CNT_LAST);
    assign fsm_state = state_q;

    // State register; reset discards any in-flight multiply.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all outputs, decoded from registered state only.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        alu_req = 1'b0;
        alu_op  = OP_ADD;
        alu_a   = '0;
        alu_b   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = mplier[0] ? S_ADD : S_SHIFT;
                end
            end
            S_ADD: begin
                busy    = 1'b1;
                alu_req = 1'b1;
                alu_op  = OP_ADD;
                alu_a   = hi;
                alu_b   = mc;
                state_d = S_CSHIFT;
            end
            S_CSHIFT: begin
                // hi now holds the truncated sum; sum < mc means it wrapped.
                busy    = 1'b1;
                alu_req = 1'b1;
                alu_op  = OP_SLTU;
                alu_a   = hi;
                alu_b   = mc;
                if (last_bit) begin
                    state_d = S_DONE;
                end else begin
                    state_d = lo[1] ? S_ADD : S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = S_DONE;
                end else begin
                    state_d = lo[1] ? S_ADD : S_SHIFT;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, partial-product accumulate and shift.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            hi  <= '0;
            lo  <= '0;
            mc  <= '0;
            cnt <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        hi  <= '0;
                        lo  <= mplier;
                        mc  <= mcand;
                        cnt <= '0;
                    end
                end
                S_ADD: begin
                    hi <= alu_out;
                end
                S_CSHIFT: begin
                    hi  <= {alu_out[0], hi[WIDTH-1:1]};
                    lo  <= {hi[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNTW'(1);
                end
                S_SHIFT: begin
                    hi  <= {1'b0, hi[WIDTH-1:1]};
                    lo  <= {hi[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNTW'(1);
                end
                default: begin
                    hi <= hi;
                end
            endcase
        end
    end

endmodule
